free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Physical-register free list; the consumer end of the ROB retire/recovery interface.
//  Pushes retired stale tags (retire_told) and, on a taken-branch squash, the squashed tags (free_list_haz).
//  Hands up to N_WAY free tags per cycle to dispatch/rename, in FIFO order.
//  Circular buffer of tags, with a registered head, tail and count.
// PARAMETERS
//  N_WAY       2   dispatch/retire width
//  N_ROB       16  ROB entries; width of the squash vector
//  N_PHYS_REG  64  physical registers; tag 0 = x0 mapping, never stored or freed
//  N_ARCH_REG  32  architectural registers; tags 0..N_ARCH_REG-1 are mapped at reset
//  TAG_BITS    6   = $clog2(N_PHYS_REG), same width as CDB tags
//  FL_DEPTH    N_PHYS_REG-N_ARCH_REG  buffer slots (derived)
// PORTS
//  clock           in   1               clock
//  reset           in   1               synchronous, active-high
//  alloc_req       in   N_WAY           dispatch slot k wants a tag; must be contiguous from bit 0
//  alloc_tag       out  N_WAY*TAG_BITS  tag for slot k; 0 when alloc_gnt[k]=0
//  alloc_gnt       out  N_WAY           slot k granted; popped at the clock edge
//  retire_valid    in   N_WAY           ROB retire strobe per way
//  retire_told     in   N_WAY*TAG_BITS  tag to free; 0 means nothing to free
//  branch_haz      in   1               ROB taken-branch squash this cycle
//  free_list_haz   in   N_ROB*TAG_BITS  squashed tags; 0 entries ignored
//  free_count      out  $clog2(N_WAY)+1 min(count, N_WAY), from registered count
//  fl_overflow     out  1               sticky error: a push was dropped with the list full
// BEHAVIOUR
//  Reset:
//   - slot i holds tag N_ARCH_REG+i; head=0, tail=0, count=FL_DEPTH.
//   - fl_overflow=0.
//   - After the reset cycle: alloc_gnt=0 and alloc_tag=0 while alloc_req=0; free_count=N_WAY.
//   - Reset mid-operation discards all in-flight pushes and pops.
//  Allocate (combinational from registered state; zero-cycle latency):
//   - alloc_gnt[k] = alloc_req[k] & (k < count) & !branch_haz.
//   - alloc_tag[k] = buf[(head+k) mod FL_DEPTH].
//   - Grants are in-order. A partial grant (count<N_WAY) grants the low slots only.
//   - head += popcount(alloc_gnt) at the edge; wraps mod FL_DEPTH (FL_DEPTH need not be a power of 2).
//  Free (tags become visible to allocation the cycle after the edge; no same-cycle bypass):
//   - Push sources, in order:
//     - retire way 0..N_WAY-1 when retire_valid & told!=0;
//     - then, if branch_haz, free_list_haz[0..N_ROB-1] entries !=0.
//   - Valid pushes are compacted and written at tail, tail+1, ... (mod FL_DEPTH); tail += pushes.
//  Simultaneous events:
//   - Pop and push in the same cycle: count_next = count - pops + pushes.
//   - A tag popped this cycle and a tag pushed this cycle never collide in the same slot (pops read head, pushes write tail).
//  Branch hazard:
//   - All grants forced to 0 that cycle; dispatch is squashed anyway.
//   - Retire and squash frees are both accepted.
//  Full:
//   - Any push beyond FL_DEPTH total is dropped.
//   - fl_overflow set and held until reset; count saturates at FL_DEPTH.
//  Width rules:
//   - head/tail are $clog2(FL_DEPTH) bits; count is $clog2(FL_DEPTH)+1 bits.
//   - Pushes per cycle are at most N_WAY+N_ROB; the sum is computed at count width+1 before saturating.
// STRUCTURE
//  - Tag typedef and the ZERO_REG_PR constant (=0) stay in the shared sys_defs package.
//  - FL_DEPTH derivation also goes in sys_defs.
//  - One sub-module: fl_push_compact. Combinational; maps the N_WAY+N_ROB candidate tags to
//    a contiguous push list plus a push count (prefix-sum based).
//  - Top level holds buf[FL_DEPTH], head, tail, count, the grant logic and the wrap arithmetic.
// TESTING
//  - Reset, no traffic: alloc_req=2'b11 -> gnt=11, tags 32,33; next cycle 34,35; free_count=2.
//  - Drain: 16 cycles of 2 allocs -> count=0, free_count=0, gnt=00.
//    Then retire told=40 -> free_count=1 next cycle; req=11 gets gnt=01, tag 40.
//  - Retire told=0 and told=37 together -> only 37 pushed; count +1.
//  - branch_haz with free_list_haz={0,45,0,50} and alloc_req=11 -> gnt=00; 45 then 50 pushed at tail; count +2.
//  - Wrap: move head/tail to 31; alloc 2 -> tags from slots 31 and 0; head=1.
//  - Overflow: full list, push 1 extra tag -> tag dropped, count stays 32, fl_overflow=1 until reset.

Source files
------------

// File: rtl/sys_defs.sv
// Shared system definitions: machine widths, the physical tag type and free-list sizing.
package sys_defs;

    localparam int unsigned N_WAY      = 2;
    localparam int unsigned N_ROB      = 16;
    localparam int unsigned N_PHYS_REG = 64;
    localparam int unsigned N_ARCH_REG = 32;
    localparam int unsigned TAG_BITS   = $clog2(N_PHYS_REG);

    typedef logic [TAG_BITS-1:0] tag_t;

    // Tag 0 is the x0 mapping; it is never stored in or freed to the list.
    localparam tag_t ZERO_REG_PR = '0;

    // Registers not mapped at reset are the ones the free list owns.
    localparam int unsigned FL_DEPTH  = N_PHYS_REG - N_ARCH_REG;
    localparam int unsigned HEAD_BITS = $clog2(FL_DEPTH);
    localparam int unsigned CNT_BITS  = HEAD_BITS + 1;

endpackage

// File: rtl/fl_push_compact.sv
// Compacts the valid candidate tags into a contiguous push list, preserving order.
module fl_push_compact
    import sys_defs::*;
#(
    parameter int unsigned N_CAND = 2,
    parameter int unsigned CNT_W  = $clog2(N_CAND + 1)
) (
    input  logic [N_CAND*TAG_BITS-1:0] cand_tags,
    input  logic [N_CAND-1:0]          cand_valid,
    output logic [N_CAND*TAG_BITS-1:0] push_tags,
    output logic [CNT_W-1:0]           push_cnt
);

    // Running prefix sum of valid bits gives each valid candidate its output slot.
    always_comb begin
        int unsigned pos;
        pos       = 0;
        push_tags = '0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            if (cand_valid[i]) begin
                push_tags[pos*TAG_BITS +: TAG_BITS] = cand_tags[i*TAG_BITS +: TAG_BITS];
                pos = pos + 1;
            end
        end
        push_cnt = CNT_W'(pos);
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular tag buffer feeding rename, refilled by retire and squash.
module free_list
    import sys_defs::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_WAY-1:0]          alloc_req,
    output logic [N_WAY*TAG_BITS-1:0] alloc_tag,
    output logic [N_WAY-1:0]          alloc_gnt,
    input  logic [N_WAY-1:0]          retire_valid,
    input  logic [N_WAY*TAG_BITS-1:0] retire_told,
    input  logic                      branch_haz,
    input  logic [N_ROB*TAG_BITS-1:0] free_list_haz,
    output logic [$clog2(N_WAY):0]    free_count,
    output logic                      fl_overflow
);

    localparam int unsigned N_CAND = N_WAY + N_ROB;
    localparam int unsigned PC_W   = $clog2(N_CAND + 1);
    localparam int unsigned POP_W  = $clog2(N_WAY + 1);
    localparam int unsigned SUM_W  = CNT_BITS + 1;
    localparam int unsigned FC_W   = $clog2(N_WAY) + 1;

    tag_t                  fl_buf [FL_DEPTH];
    logic [HEAD_BITS-1:0]  head;
    logic [HEAD_BITS-1:0]  tail;
    logic [CNT_BITS-1:0]   count;
    logic [CNT_BITS-1:0]   count_next;
    logic [POP_W-1:0]      pop_cnt;
    logic [PC_W-1:0]       push_cnt;
    logic [PC_W-1:0]       accept_cnt;
    logic [SUM_W-1:0]      sum_cnt;
    logic [SUM_W-1:0]      room;
    logic                  drop;
    logic [N_CAND-1:0]          cand_valid;
    logic [N_CAND*TAG_BITS-1:0] cand_tags;
    logic [N_CAND*TAG_BITS-1:0] push_tags;

    // Circular index advance; FL_DEPTH is not required to be a power of two.
    function automatic logic [HEAD_BITS-1:0] wrap_add(input logic [HEAD_BITS-1:0] base,
                                                      input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return HEAD_BITS'(s % FL_DEPTH);
    endfunction

    // Gather push candidates: retire ways first, then squashed tags when a branch hazard fires.
    always_comb begin
        cand_tags  = '0;
        cand_valid = '0;
        for (int unsigned k = 0; k < N_WAY; k++) begin
            cand_tags[k*TAG_BITS +: TAG_BITS] = retire_told[k*TAG_BITS +: TAG_BITS];
            cand_valid[k] = retire_valid[k] && (retire_told[k*TAG_BITS +: TAG_BITS] != ZERO_REG_PR);
        end
        for (int unsigned j = 0; j < N_ROB; j++) begin
            cand_tags[(N_WAY+j)*TAG_BITS +: TAG_BITS] = free_list_haz[j*TAG_BITS +: TAG_BITS];
            cand_valid[N_WAY+j] = branch_haz && (free_list_haz[j*TAG_BITS +: TAG_BITS] != ZERO_REG_PR);
        end
    end

    fl_push_compact #(
        .N_CAND (N_CAND),
        .CNT_W  (PC_W)
    ) u_compact (
        .cand_tags  (cand_tags),
        .cand_valid (cand_valid),
        .push_tags  (push_tags),
        .push_cnt   (push_cnt)
    );

    // In-order grants straight from registered state; suppressed during a branch squash.
    always_comb begin
        alloc_gnt = '0;
        alloc_tag = '0;
        pop_cnt   = '0;
        for (int unsigned k = 0; k < N_WAY; k++) begin
            if (alloc_req[k] && (CNT_BITS'(k) < count) && !branch_haz) begin
                alloc_gnt[k] = 1'b1;
                alloc_tag[k*TAG_BITS +: TAG_BITS] = fl_buf[wrap_add(head, k)];
                pop_cnt = pop_cnt + POP_W'(1);
            end
        end
    end

    // Occupancy update with saturation; pushes past the free room are dropped.
    always_comb begin
        sum_cnt    = SUM_W'(count) - SUM_W'(pop_cnt) + SUM_W'(push_cnt);
        room       = SUM_W'(FL_DEPTH) - (SUM_W'(count) - SUM_W'(pop_cnt));
        drop       = sum_cnt > SUM_W'(FL_DEPTH);
        accept_cnt = drop ? PC_W'(room) : push_cnt;
        count_next = drop ? CNT_BITS'(FL_DEPTH) : CNT_BITS'(sum_cnt);
    end

    // Report at most N_WAY available tags, which is all dispatch can use.
    always_comb begin
        free_count = (count >= CNT_BITS'(N_WAY)) ? FC_W'(N_WAY) : FC_W'(count);
    end

    // Pointer, count and sticky overflow registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= CNT_BITS'(FL_DEPTH);
            fl_overflow <= 1'b0;
        end else begin
            head  <= wrap_add(head, 32'(pop_cnt));
            tail  <= wrap_add(tail, 32'(accept_cnt));
            count <= count_next;
            if (drop) begin
                fl_overflow <= 1'b1;
            end
        end
    end

    // Tag storage: reset preloads the unmapped registers, accepted pushes land at tail onward.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                fl_buf[i] <= TAG_BITS'(N_ARCH_REG + i);
            end
        end else begin
            for (int unsigned i = 0; i < N_CAND; i++) begin
                if (PC_W'(i) < accept_cnt) begin
                    fl_buf[wrap_add(tail, i)] <= push_tags[i*TAG_BITS +: TAG_BITS];
                end
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list against a queue-based reference model.
module tb_free_list;
    import sys_defs::*;

    logic                      clock;
    logic                      reset;
    logic [N_WAY-1:0]          alloc_req;
    logic [N_WAY*TAG_BITS-1:0] alloc_tag;
    logic [N_WAY-1:0]          alloc_gnt;
    logic [N_WAY-1:0]          retire_valid;
    logic [N_WAY*TAG_BITS-1:0] retire_told;
    logic                      branch_haz;
    logic [N_ROB*TAG_BITS-1:0] free_list_haz;
    logic [$clog2(N_WAY):0]    free_count;
    logic                      fl_overflow;

    int total;
    int bad;
    int model_q[$];
    int model_ovf;

    free_list dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .alloc_tag     (alloc_tag),
        .alloc_gnt     (alloc_gnt),
        .retire_valid  (retire_valid),
        .retire_told   (retire_told),
        .branch_haz    (branch_haz),
        .free_list_haz (free_list_haz),
        .free_count    (free_count),
        .fl_overflow   (fl_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alloc_req     = '0;
        retire_valid  = '0;
        retire_told   = '0;
        branch_haz    = 1'b0;
        free_list_haz = '0;
    endtask

    task automatic model_reset();
        model_q.delete();
        for (int i = 0; i < int'(FL_DEPTH); i++) model_q.push_back(int'(N_ARCH_REG) + i);
        model_ovf = 0;
    endtask

    function automatic void model_push(input int t);
        if (t == 0) return;
        if (model_q.size() < int'(FL_DEPTH)) model_q.push_back(t);
        else model_ovf = 1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: compare outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        logic [N_WAY-1:0]          eg;
        logic [N_WAY*TAG_BITS-1:0] et;
        int np;
        int fc;
        @(negedge clock);
        eg = '0;
        et = '0;
        for (int k = 0; k < int'(N_WAY); k++) begin
            if (alloc_req[k] && k < model_q.size() && !branch_haz) begin
                eg[k] = 1'b1;
                et[k*TAG_BITS +: TAG_BITS] = TAG_BITS'(model_q[k]);
            end
        end
        fc = (model_q.size() < int'(N_WAY)) ? model_q.size() : int'(N_WAY);
        check("alloc_gnt", int'(alloc_gnt), int'(eg));
        check("alloc_tag", int'(alloc_tag), int'(et));
        check("free_count", int'(free_count), fc);
        check("fl_overflow", int'(fl_overflow), model_ovf);
        np = $countones(eg);
        for (int k = 0; k < np; k++) void'(model_q.pop_front());
        for (int k = 0; k < int'(N_WAY); k++)
            if (retire_valid[k]) model_push(int'(retire_told[k*TAG_BITS +: TAG_BITS]));
        if (branch_haz)
            for (int j = 0; j < int'(N_ROB); j++)
                model_push(int'(free_list_haz[j*TAG_BITS +: TAG_BITS]));
        @(posedge clock);
        #1;
    endtask

    task automatic rand_inputs(input int alloc_pct, input int ret_pct, input int haz_pct);
        alloc_req = ($urandom_range(0, 99) < alloc_pct) ? ($urandom_range(0, 1) ? 2'b11 : 2'b01) : 2'b00;
        for (int k = 0; k < int'(N_WAY); k++) begin
            retire_valid[k] = ($urandom_range(0, 99) < ret_pct);
            retire_told[k*TAG_BITS +: TAG_BITS] = ($urandom_range(0, 7) == 0) ? '0 : TAG_BITS'($urandom_range(1, 63));
        end
        branch_haz = ($urandom_range(0, 99) < haz_pct);
        for (int j = 0; j < int'(N_ROB); j++)
            free_list_haz[j*TAG_BITS +: TAG_BITS] = ($urandom_range(0, 3) == 0) ? TAG_BITS'($urandom_range(1, 63)) : '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b1;
        do_reset();

        // Reset state and first allocations.
        cycle();
        alloc_req = 2'b11;
        #1;
        check("first_tag0", int'(alloc_tag[TAG_BITS-1:0]), 32);
        check("first_tag1", int'(alloc_tag[2*TAG_BITS-1:TAG_BITS]), 33);
        cycle();
        check("second_tag0", int'(alloc_tag[TAG_BITS-1:0]), 34);
        check("second_tag1", int'(alloc_tag[2*TAG_BITS-1:TAG_BITS]), 35);
        for (int i = 0; i < 15; i++) cycle();

        // Drained list, then a single retired tag comes back.
        check("drained_free_count", int'(free_count), 0);
        check("drained_gnt", int'(alloc_gnt), 0);
        alloc_req = 2'b00;
        retire_valid = 2'b01;
        retire_told[TAG_BITS-1:0] = TAG_BITS'(40);
        cycle();
        retire_valid = 2'b00;
        alloc_req = 2'b11;
        #1;
        check("refill_free_count", int'(free_count), 1);
        check("partial_gnt", int'(alloc_gnt), 1);
        check("partial_tag", int'(alloc_tag[TAG_BITS-1:0]), 40);
        cycle();

        // Zero told is ignored; only 37 comes back.
        alloc_req = 2'b00;
        retire_valid = 2'b11;
        retire_told = {TAG_BITS'(37), TAG_BITS'(0)};
        cycle();
        idle_inputs();
        #1;
        check("told_zero_count", int'(free_count), 1);
        cycle();

        // Branch squash: no grants, 45 then 50 pushed.
        alloc_req = 2'b11;
        branch_haz = 1'b1;
        free_list_haz[1*TAG_BITS +: TAG_BITS] = TAG_BITS'(45);
        free_list_haz[3*TAG_BITS +: TAG_BITS] = TAG_BITS'(50);
        #1;
        check("haz_gnt", int'(alloc_gnt), 0);
        cycle();
        idle_inputs();
        alloc_req = 2'b11;
        #1;
        check("haz_tag0", int'(alloc_tag[TAG_BITS-1:0]), 37);
        check("haz_tag1", int'(alloc_tag[2*TAG_BITS-1:TAG_BITS]), 45);
        cycle();
        alloc_req = 2'b01;
        #1;
        check("haz_tag2", int'(alloc_tag[TAG_BITS-1:0]), 50);
        cycle();

        // Wrap: move head and tail to slot 31, then allocate across the boundary.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_req    = (i == 15) ? 2'b01 : 2'b11;
            retire_valid = (i == 15) ? 2'b01 : 2'b11;
            retire_told  = {TAG_BITS'(2*i + 2), TAG_BITS'(2*i + 1)};
            cycle();
        end
        idle_inputs();
        alloc_req = 2'b11;
        #1;
        check("wrap_tag_slot31", int'(alloc_tag[TAG_BITS-1:0]), 63);
        check("wrap_tag_slot0", int'(alloc_tag[2*TAG_BITS-1:TAG_BITS]), 1);
        cycle();

        // Overflow: push into a full list.
        idle_inputs();
        do_reset();
        retire_valid = 2'b01;
        retire_told[TAG_BITS-1:0] = TAG_BITS'(41);
        cycle();
        idle_inputs();
        #1;
        check("ovf_set", int'(fl_overflow), 1);
        check("ovf_free_count", int'(free_count), 2);
        for (int i = 0; i < 3; i++) cycle();
        alloc_req = 2'b11;
        #1;
        check("ovf_tag_unchanged", int'(alloc_tag[TAG_BITS-1:0]), 32);
        cycle();
        idle_inputs();
        do_reset();
        #1;
        check("ovf_cleared", int'(fl_overflow), 0);

        // Randomized traffic in phases with different biases, including mid-run resets.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 600; i++) begin
                case (p)
                    0: rand_inputs(90, 20, 3);
                    1: rand_inputs(20, 90, 5);
                    2: rand_inputs(60, 50, 30);
                    default: rand_inputs(70, 60, 10);
                endcase
                if ($urandom_range(0, 299) == 0) do_reset();
                else cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
